sextium_bus_master: RTL and testbench

Initiator side of the Sextium III asynchronous memory bus. Accepts single-word read/write commands from the CPU core and drives `read`/`write`/`addr`/`data_out` toward the memory. Completes a full four-phase handshake on `ack` and returns read data to the core with a one-cycle valid pulse. It sits between the core's fetch/load/store logic and any memory responder on the bus: the simulated memory in benches, block RAM glue on hardware.

---
 rtl/sextium_bus_master.sv | 175 +++++++++++++++++
 tb/tb_sextium_bus_master.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sextium_bus_master.sv
`timescale 1ns/1ps
// sextium_bus_master
//   Initiator side of the Sextium III asynchronous memory bus. Takes one
//   read or write command at a time from the core, runs a four-phase
//   handshake (strobe up, ack up, strobe down, ack down) and reports
//   completion with a one-cycle resp_valid pulse.
//
//   Optional feature: define BUS_TIMEOUT_EN to compile in a per-phase wait
//   limit of TIMEOUT cycles; on expiry the strobe is dropped and err pulses.
//   Without the macro there is no counter, err is constant 0 and the master
//   waits for the responder indefinitely.
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   req_read, req_write  core command (read wins if both are set)
//   req_addr, req_wdata  command address and write data
//   busy                 command cannot be accepted this cycle
//   resp_valid           one-cycle completion pulse
//   resp_rdata           last read data, held until the next read completes
//   err                  one-cycle abort pulse (timeout build only)
//   read, write          registered memory strobes
//   addr, data_out       memory address / write data, stable per command
//   data_in, ack         memory read data and acknowledge
module sextium_bus_master #(
    parameter int unsigned TIMEOUT   = 255,
    parameter int unsigned TIMEOUT_W = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        err,
    output logic        read,
    output logic        write,
    output logic [15:0] addr,
    output logic [15:0] data_out,
    input  logic [15:0] data_in,
    input  logic        ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic   accept;
    logic   tmo_hit;
    logic   read_nxt;
    logic   write_nxt;
    logic   resp_valid_nxt;
    logic   err_nxt;
    logic   cap_rdata;

    // A lingering ack from a previous (possibly reset-aborted) transfer keeps
    // the master busy so a new strobe never overlaps the old handshake.
    assign busy   = (state != S_IDLE) | ack;
    assign accept = !busy && (req_read || req_write);

`ifdef BUS_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] tmo_cnt;

    assign tmo_hit = (tmo_cnt == TIMEOUT_W'(TIMEOUT));

    // Restarts on every state change, so each wait phase gets its own budget.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
        end else if (state != state_nxt) begin
            tmo_cnt <= '0;
        end else if (state != S_IDLE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;

    // The timeout parameters only matter when the counter is compiled in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT < (32'd1 << TIMEOUT_W));
`endif

    // State register plus the registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            read       <= 1'b0;
            write      <= 1'b0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            addr       <= '0;
            data_out   <= '0;
            resp_rdata <= '0;
        end else begin
            state      <= state_nxt;
            read       <= read_nxt;
            write      <= write_nxt;
            resp_valid <= resp_valid_nxt;
            err        <= err_nxt;
            if (accept) begin
                addr     <= req_addr;
                data_out <= req_read ? 16'h0000 : req_wdata;
            end
            if (cap_rdata) begin
                resp_rdata <= data_in;
            end
        end
    end

    // Next-state logic; a real ack always takes priority over the timeout.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = S_REQ;
            S_REQ: begin
                if (ack)          state_nxt = S_REL;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            S_REL: begin
                if (!ack)         state_nxt = S_IDLE;
                else if (tmo_hit) state_nxt = S_IDLE;
            end
            default:              state_nxt = S_IDLE;
        endcase
    end

    // Output logic: next values for the registered strobes and pulses.
    always_comb begin
        read_nxt       = read;
        write_nxt      = write;
        resp_valid_nxt = 1'b0;
        err_nxt        = 1'b0;
        cap_rdata      = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    read_nxt  = req_read;
                    write_nxt = req_write & ~req_read;
                end
            end
            S_REQ: begin
                if (ack) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    // read is only high in REQ for a read command
                    cap_rdata = read;
                end else if (tmo_hit) begin
                    read_nxt  = 1'b0;
                    write_nxt = 1'b0;
                    err_nxt   = 1'b1;
                end
            end
            S_REL: begin
                if (!ack) begin
                    resp_valid_nxt = 1'b1;
                end else if (tmo_hit) begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                read_nxt  = 1'b0;
                write_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_sextium_bus_master.sv
`timescale 1ns/1ps
module tb_sextium_bus_master;

    logic        clk;
    logic        rst;
    logic        req_read;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        busy;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        err;
    logic        read;
    logic        write;
    logic [15:0] addr;
    logic [15:0] data_out;
    logic [15:0] data_in;
    logic        ack;

    logic        ack_resp;
    logic        ack_force;
    logic        resp_en;
    int          rel_delay;
    logic [15:0] mem [0:255];

    int n_checks = 0;
    int n_errors = 0;

    int read_cycles  = 0;
    int write_cycles = 0;
    int resp_cnt     = 0;
    int err_cnt      = 0;
    int both_cnt     = 0;
    int hold_chg     = 0;
    logic        prev_hold = 1'b0;
    logic        prev_rst  = 1'b1;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_dout = '0;

    assign ack = ack_resp | ack_force;

    sextium_bus_master #(.TIMEOUT(4), .TIMEOUT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_read   (req_read),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .err        (err),
        .read       (read),
        .write      (write),
        .addr       (addr),
        .data_out   (data_out),
        .data_in    (data_in),
        .ack        (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simulated memory responder: ack 5 ns after a strobe rises, release
    // rel_delay ns after the strobe falls.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[8'h10] = 16'hBEEF;
        mem[8'h30] = 16'h5A5A;
        ack_resp = 1'b0;
        data_in  = 16'h0000;
        forever begin
            wait (resp_en && (read || write));
            #5;
            ack_resp = 1'b1;
            if (read) data_in = mem[addr[7:0]];
            else      mem[addr[7:0]] = data_out;
            wait (!read && !write);
            #(rel_delay);
            ack_resp = 1'b0;
            data_in  = 16'h0000;
        end
    end

    // Bus monitor
    always @(posedge clk) begin
        if (read)              read_cycles  <= read_cycles + 1;
        if (write)             write_cycles <= write_cycles + 1;
        if (resp_valid)        resp_cnt     <= resp_cnt + 1;
        if (err)               err_cnt      <= err_cnt + 1;
        if (resp_valid && err) both_cnt     <= both_cnt + 1;
        if (prev_hold && !prev_rst && (addr != prev_addr || data_out != prev_dout))
            hold_chg <= hold_chg + 1;
        prev_hold <= read | write | ack;
        prev_rst  <= rst;
        prev_addr <= addr;
        prev_dout <= data_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command and wait (bounded) for resp_valid; returns at the
    // negedge where resp_valid is seen, with lat = negedges after accept.
    task automatic run_cmd(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [15:0] wd, output int lat);
        @(negedge clk);
        req_read  = rd;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_read  = 1'b0;
        req_write = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("resp_valid_seen", {31'd0, resp_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0, w0, v0, e0;

        rst       = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        ack_force = 1'b0;
        resp_en   = 1'b1;
        rel_delay = 5;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_read",   {31'd0, read},       32'd0);
        check("rst_write",  {31'd0, write},      32'd0);
        check("rst_addr",   {16'd0, addr},       32'd0);
        check("rst_dout",   {16'd0, data_out},   32'd0);
        check("rst_rdata",  {16'd0, resp_rdata}, 32'd0);
        check("rst_valid",  {31'd0, resp_valid}, 32'd0);
        check("rst_err",    {31'd0, err},        32'd0);
        check("rst_busy",   {31'd0, busy},       32'd0);

        // Single read of 0x0010
        r0 = read_cycles; v0 = resp_cnt;
        run_cmd(1'b1, 1'b0, 16'h0010, 16'h0000, lat);
        check("rd_latency", lat, 32'd2);
        check("rd_rdata",   {16'd0, resp_rdata}, 32'h0000BEEF);
        check("rd_busy_in_valid", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check("rd_valid_one_cycle", {31'd0, resp_valid}, 32'd0);
        check("rd_strobe_cycles", read_cycles - r0, 32'd1);
        check("rd_resp_count",    resp_cnt - v0,    32'd1);

        // Write 0x1234 to 0x0020, then read it back
        w0 = write_cycles;
        run_cmd(1'b0, 1'b1, 16'h0020, 16'h1234, lat);
        check("wr_latency",  lat, 32'd2);
        check("wr_mem",      {16'd0, mem[8'h20]}, 32'h00001234);
        check("wr_addr_held", {16'd0, addr},      32'h00000020);
        check("wr_dout_held", {16'd0, data_out},  32'h00001234);
        @(negedge clk);
        check("wr_strobe_cycles", write_cycles - w0, 32'd1);
        run_cmd(1'b1, 1'b0, 16'h0020, 16'hFFFF, lat);
        check("rb_rdata", {16'd0, resp_rdata}, 32'h00001234);
        check("rb_dout_zero", {16'd0, data_out}, 32'd0);

        // Read and write together: read wins
        @(negedge clk);
        r0 = read_cycles; w0 = write_cycles; v0 = resp_cnt;
        run_cmd(1'b1, 1'b1, 16'h0030, 16'hFFFF, lat);
        @(negedge clk);
        check("both_rdata",      {16'd0, resp_rdata}, 32'h00005A5A);
        check("both_mem_intact", {16'd0, mem[8'h30]}, 32'h00005A5A);
        check("both_rd_cycles",  read_cycles - r0,  32'd1);
        check("both_wr_cycles",  write_cycles - w0, 32'd0);
        check("both_resp_count", resp_cnt - v0,     32'd1);

        // Stale ack blocks acceptance
        @(negedge clk);
        ack_force = 1'b1;
        #1;
        check("stale_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        req_read = 1'b1;
        req_addr = 16'h0010;
        repeat (3) @(negedge clk);
        check("stale_no_strobe", {31'd0, read}, 32'd0);
        ack_force = 1'b0;
        @(negedge clk);
        check("stale_accept", {31'd0, read}, 32'd1);
        req_read = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check("stale_rdata", {16'd0, resp_rdata}, 32'h0000BEEF);

        // Responder that never acks
        @(negedge clk);
        resp_en = 1'b0;
        r0 = read_cycles; v0 = resp_cnt; e0 = err_cnt;
        req_read = 1'b1;
        req_addr = 16'h0040;
        @(negedge clk);
        req_read = 1'b0;
`ifdef BUS_TIMEOUT_EN
        repeat (20) @(negedge clk);
        check("tmo_strobe_cycles", read_cycles - r0, 32'd5);
        check("tmo_read_low",      {31'd0, read},    32'd0);
        check("tmo_err_count",     err_cnt - e0,     32'd1);
        check("tmo_no_resp",       resp_cnt - v0,    32'd0);
        check("tmo_rdata_kept",    {16'd0, resp_rdata}, 32'h0000BEEF);
`else
        repeat (1000) @(negedge clk);
        check("noack_read_high", {31'd0, read},  32'd1);
        check("noack_no_err",    err_cnt - e0,   32'd0);
        check("noack_no_resp",   resp_cnt - v0,  32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("noack_rst_read",  {31'd0, read},  32'd0);
`endif
        resp_en = 1'b1;
        @(negedge clk);

        // Reset while the responder still holds ack (REL)
        rel_delay = 25;
        v0 = resp_cnt; e0 = err_cnt;
        @(negedge clk);
        req_read = 1'b1;
        req_addr = 16'h0010;
        @(negedge clk);
        req_read = 1'b0;
        @(negedge clk);
        check("rel_strobe_dropped", {31'd0, read}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("relrst_read",  {31'd0, read},       32'd0);
        check("relrst_write", {31'd0, write},      32'd0);
        check("relrst_addr",  {16'd0, addr},       32'd0);
        check("relrst_dout",  {16'd0, data_out},   32'd0);
        check("relrst_rdata", {16'd0, resp_rdata}, 32'd0);
        check("relrst_busy",  {31'd0, busy},       32'd1);
        repeat (5) @(negedge clk);
        check("relrst_no_resp", resp_cnt - v0, 32'd0);
        check("relrst_no_err",  err_cnt - e0,  32'd0);
        check("relrst_idle",    {31'd0, busy}, 32'd0);
        rel_delay = 5;
        run_cmd(1'b1, 1'b0, 16'h0020, 16'h0000, lat);
        check("post_rst_rdata", {16'd0, resp_rdata}, 32'h00001234);
        check("post_rst_latency", lat, 32'd2);

        repeat (3) @(negedge clk);
        check("addr_data_stable", hold_chg, 32'd0);
        check("valid_err_exclusive", both_cnt, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
